// File: rtl/counter_pkg.sv
// Shared definitions for the JK-flip-flop counter.
//   CNT_WIDTH  : default counter width in bits
//   jk_mode_e  : {J,K} control encodings (HOLD, CLR, SET, TOG)
package counter_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TOG  = 2'b11
  } jk_mode_e;

endpackage

// File: rtl/counter_if.sv
// Bus bundle between the counter and whatever drives it.
//   J, K : shared JK controls (driven by master)
//   Q    : registered counter state (driven by slave)
interface counter_if #(
  parameter int WIDTH = counter_pkg::CNT_WIDTH
) ();

  logic             J;
  logic             K;
  logic [WIDTH-1:0] Q;

  modport master (output J, output K, input  Q);
  modport slave  (input  J, input  K, output Q);

endinterface

// File: rtl/counter_jk_ff.sv
// Single JK flip-flop stage with synchronous active-high reset.
//   CLK : clock, rising edge
//   RST : synchronous reset, forces q to 0
//   j,k : JK inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   q   : registered output
module jk_ff
  import counter_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      HOLD:    q_d = q_q;
      CLR:     q_d = 1'b0;
      SET:     q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/counter.sv
// Synchronous binary counter built from a chain of JK flip-flops.
// Each stage sees the shared J/K gated by the carry of the bits below it,
// giving hold / count-up / carry-gated set / carry-gated clear modes.
//   CLK : system clock, rising edge
//   RST : synchronous active-high reset, Q -> 0
//   bus : counter_if.slave carrying J, K (in) and Q (out)
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic      CLK,
  input  logic      RST,
  counter_if.slave  bus
);

  logic [WIDTH-1:0] e;    // stage enables: AND of all lower bits
  logic [WIDTH-1:0] q_w;  // collected stage outputs

  // Enables use the pre-edge Q, so every stage updates in the same edge
  // rather than rippling.
  assign e[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign e[i] = e[i-1] & q_w[i-1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_ff u_ff (
      .CLK (CLK),
      .RST (RST),
      .j   (bus.J & e[i]),
      .k   (bus.K & e[i]),
      .q   (q_w[i])
    );
  end

  assign bus.Q = q_w;

endmodule

// File: tb/tb_counter.sv
// Testbench for counter: table of directed vectors, a random phase checked
// against a behavioural model, and a hand-written check that J/K changes
// between edges do not reach Q.
module tb_counter;
  import counter_pkg::*;

  localparam int W = CNT_WIDTH;

  logic CLK = 1'b0;
  logic RST;

  counter_if #(.WIDTH(W)) bus ();

  counter #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         rst;
    logic [1:0]   jk;
    logic [W-1:0] q;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] model_q;
  int           checks = 0;
  int           errors = 0;

  function automatic void add(input logic r, input logic [1:0] jk, input int q);
    vec_t v;
    v.rst = r;
    v.jk  = jk;
    v.q   = W'(q);
    tbl.push_back(v);
  endfunction

  // Carry-gated enable mask: bits whose lower bits are all ones, plus bit 0.
  function automatic logic [W-1:0] model(input logic [W-1:0] q, input logic r,
                                         input logic [1:0] jk);
    logic [W-1:0] inc;
    logic [W-1:0] e;
    inc = W'(q + 1'b1);
    e   = q ^ inc;
    if (r) return '0;
    case (jk)
      HOLD:    return q;
      TOG:     return inc;
      SET:     return q | e;
      default: return q & ~e;
    endcase
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: Q=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] jk, input logic [W-1:0] exp,
                       input string nm);
    logic [W-1:0] e;
    @(negedge CLK);
    RST   = r;
    bus.J = jk[1];
    bus.K = jk[0];
    sb.push_back(exp);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      check(nm, bus.Q, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST   = 1'b1;
    bus.J = 1'b0;
    bus.K = 1'b0;

    // Reset with count requested
    add(1, TOG, 0); add(1, TOG, 0);
    // Full count including wrap
    for (int i = 1; i <= 15; i++) add(0, TOG, i);
    add(0, TOG, 0); add(0, TOG, 1);
    // Count to 0110, then hold
    for (int i = 2; i <= 6; i++) add(0, TOG, i);
    for (int i = 0; i < 5; i++) add(0, HOLD, 6);
    // Set from 0101
    add(1, HOLD, 0);
    for (int i = 1; i <= 5; i++) add(0, TOG, i);
    add(0, SET, 7); add(0, SET, 15); add(0, SET, 15);
    // Clear from 0101
    add(1, HOLD, 0);
    for (int i = 1; i <= 5; i++) add(0, TOG, i);
    add(0, CLR, 4); add(0, CLR, 4);
    // Reset mid-count at 1011
    add(1, TOG, 0);
    for (int i = 1; i <= 11; i++) add(0, TOG, i);
    add(1, TOG, 0); add(0, TOG, 1);
    // Clear from 0001 and at 0000
    add(0, CLR, 0); add(0, CLR, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].jk, tbl[i].q, $sformatf("vec%0d", i));
      model_q = tbl[i].q;
    end

    // J/K wiggling between edges must not reach Q
    @(negedge CLK);
    RST   = 1'b0;
    bus.J = 1'b1; bus.K = 1'b1;
    #1 check("no_comb_tog", bus.Q, model_q);
    bus.J = 1'b0; bus.K = 1'b1;
    #1 check("no_comb_clr", bus.Q, model_q);
    bus.J = 1'b0; bus.K = 1'b0;
    @(posedge CLK);
    #1 check("no_comb_hold", bus.Q, model_q);

    // Random mix against the model
    for (int n = 0; n < 80; n++) begin
      logic         r;
      logic [1:0]   jk;
      logic [W-1:0] exp;
      r   = ($urandom_range(0, 15) == 0);
      jk  = 2'($urandom_range(0, 3));
      exp = model(model_q, r, jk);
      drive(r, jk, exp, $sformatf("rnd%0d", n));
      model_q = exp;
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
